// File: rtl/pwm_capture.sv
// ============================================================================
//  Module      : pwm_capture
//  Description : Measures the period (rise to rise) and the high time of an
//                external PWM input in clk cycles, with overflow and stability flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_capture #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W:0]   period_out,
  output logic [CNT_W:0]   high_out,
  output logic             valid,
  output logic             ovf,
  output logic             stable
);

  localparam logic [CNT_W:0] MAX = '1;
  localparam logic [CNT_W:0] ONE = {{CNT_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic             s0, s1, s2;
  logic             rise, fall;
  logic [CNT_W:0]   per_cnt, per_d, per_inc;
  logic [CNT_W:0]   hi_cnt, hi_d, hi_inc;
  logic [CNT_W:0]   period_d, high_d;
  logic             valid_d, ovf_d, stable_d;
  logic             prev_ok, prev_ok_d;
  logic [CNT_W:0]   prev_per, prev_per_d, prev_hi, prev_hi_d;

  assign rise    = s1 & ~s2;
  assign fall    = ~s1 & s2;
  assign per_inc = (per_cnt == MAX) ? MAX : per_cnt + ONE;
  assign hi_inc  = (hi_cnt == MAX) ? MAX : hi_cnt + ONE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0         <= 1'b0;
      s1         <= 1'b0;
      s2         <= 1'b0;
      state      <= IDLE;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      period_out <= '0;
      high_out   <= '0;
      valid      <= 1'b0;
      ovf        <= 1'b0;
      stable     <= 1'b0;
      prev_ok    <= 1'b0;
      prev_per   <= '0;
      prev_hi    <= '0;
    end else begin
      s0         <= pwm_in;
      s1         <= s0;
      s2         <= s1;
      state      <= state_d;
      per_cnt    <= per_d;
      hi_cnt     <= hi_d;
      period_out <= period_d;
      high_out   <= high_d;
      valid      <= valid_d;
      ovf        <= ovf_d;
      stable     <= stable_d;
      prev_ok    <= prev_ok_d;
      prev_per   <= prev_per_d;
      prev_hi    <= prev_hi_d;
    end
  end

  always_comb begin
    state_d    = state;
    per_d      = per_cnt;
    hi_d       = hi_cnt;
    period_d   = period_out;
    high_d     = high_out;
    valid_d    = 1'b0;
    ovf_d      = ovf;
    stable_d   = stable;
    prev_ok_d  = prev_ok;
    prev_per_d = prev_per;
    prev_hi_d  = prev_hi;

    case (state)
      IDLE: begin
        if (rise) begin
          per_d   = ONE;
          hi_d    = ONE;
          state_d = HIGH;
        end
      end
      HIGH, LOW: begin
        // A rise takes priority over timeout so a period of exactly MAX is a normal result
        if (rise) begin
          period_d = per_cnt;
          high_d   = hi_cnt;
          valid_d  = 1'b1;
          ovf_d    = 1'b0;
          per_d    = ONE;
          hi_d     = ONE;
          state_d  = HIGH;
        end else if (per_cnt == MAX) begin
          period_d = MAX;
          high_d   = hi_cnt;
          valid_d  = 1'b1;
          ovf_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          per_d = per_inc;
          if (state == HIGH) begin
            if (fall) state_d = LOW;
            else      hi_d    = hi_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (valid_d) begin
      if (ovf_d) begin
        stable_d  = 1'b0;
        prev_ok_d = 1'b0;
      end else begin
        stable_d   = prev_ok && (prev_per == period_d) && (prev_hi == high_d);
        prev_ok_d  = 1'b1;
        prev_per_d = period_d;
        prev_hi_d  = high_d;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_capture.sv
// ============================================================================
//  Module      : tb_pwm_capture
//  Description : Directed scoreboard bench for pwm_capture.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwm_in = 1'b0;
  logic [3:0] period_out, high_out;
  logic       valid, ovf, stable;

  typedef struct {
    int per;
    int hi;
    int ovf;
    int stb;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   last_rise_cyc = 0;

  pwm_capture #(.CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .period_out (period_out),
    .high_out   (high_out),
    .valid      (valid),
    .ovf        (ovf),
    .stable     (stable)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int per, input int hi, input int o, input int stb);
    exp_t e;
    e.per = per; e.hi = hi; e.ovf = o; e.stb = stb;
    sb.push_back(e);
  endtask

  task automatic pulse(input int h, input int l);
    pwm_in = 1'b1;
    last_rise_cyc = cyc;
    repeat (h) step();
    pwm_in = 1'b0;
    repeat (l) step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, int'(period_out), 0);
    chk({tag, "_high"},   int'(high_out), 0);
    chk({tag, "_valid"},  int'(valid), 0);
    chk({tag, "_ovf"},    int'(ovf), 0);
    chk({tag, "_stable"}, int'(stable), 0);
  endtask

  // Monitor: every valid pulse consumes exactly one expected measurement
  always @(negedge clk) begin
    if (valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("period_out", int'(period_out), e.per);
        chk("high_out",   int'(high_out), e.hi);
        chk("ovf",        int'(ovf), e.ovf);
        chk("stable",     int'(stable), e.stb);
        if (e.ovf == 0) chk("valid_latency", cyc - last_rise_cyc, 3);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    pwm_in = 1'b0;
    repeat (3) step();
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (4) step();
    chk("idle_valid", int'(valid), 0);

    // T1: 8/3 repeating
    pulse(3, 5);
    push(8, 3, 0, 0); pulse(3, 5);
    push(8, 3, 0, 1); pulse(3, 5);
    push(8, 3, 0, 1); pulse(3, 5);

    // T2: duty codes 1..7 at period 8, then code 0
    push(8, 3, 0, 1); pulse(1, 7);
    push(8, 1, 0, 0); pulse(2, 6);
    push(8, 2, 0, 0); pulse(3, 5);
    push(8, 3, 0, 0); pulse(4, 4);
    push(8, 4, 0, 0); pulse(5, 3);
    push(8, 5, 0, 0); pulse(6, 2);
    push(8, 6, 0, 0); pulse(7, 1);
    push(15, 7, 1, 0);
    repeat (40) step();

    // T3: normal period, then stuck high
    pulse(3, 5);
    push(8, 3, 0, 0);
    push(15, 15, 1, 0);
    pulse(40, 5);
    pulse(3, 5);
    push(8, 3, 0, 0); pulse(3, 5);
    push(8, 3, 0, 1);

    // T4: period 15, 1 high (rise coincides with saturation)
    pulse(1, 14);
    push(15, 1, 0, 0); pulse(1, 14);
    push(15, 1, 0, 1);

    // T5: reset in the middle of a high phase
    pwm_in = 1'b1;
    last_rise_cyc = cyc;
    repeat (5) step();
    rst_n = 1'b0;
    pwm_in = 1'b0;
    step();
    rst_n = 1'b1;
    chk_zero("midreset");
    repeat (4) step();
    pulse(3, 5);
    push(8, 3, 0, 0); pulse(3, 5);

    // T6: 8/3 switches to 8/5
    push(8, 3, 0, 1); pulse(5, 3);
    push(8, 5, 0, 0); pulse(5, 3);
    push(8, 5, 0, 1); pulse(5, 3);
    push(8, 5, 0, 1);
    push(15, 15, 1, 0);
    pwm_in = 1'b1;
    last_rise_cyc = cyc;
    repeat (30) step();
    pwm_in = 1'b0;
    repeat (5) step();

    chk("pending_expectations", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
